// File: rtl/all_gate_bist_ctrl_if.sv
// Handshake and gate-stimulus bundle between the BIST sequencer and its surroundings.
// The master side is the system/all_gate environment; the slave side is the sequencer.
interface all_gate_bist_ctrl_if;
   logic       start;
   logic       abort;
   logic       a_o;
   logic       b_o;
   logic       and_i;
   logic       or_i;
   logic       xor_i;
   logic       nand_i;
   logic       nor_i;
   logic       busy;
   logic       done;
   logic       pass;
   logic [4:0] err_vec;
   logic [3:0] fail_vec;
   logic [1:0] vec_idx;

   modport master (
      output start, abort, and_i, or_i, xor_i, nand_i, nor_i,
      input  a_o, b_o, busy, done, pass, err_vec, fail_vec, vec_idx
   );

   modport slave (
      input  start, abort, and_i, or_i, xor_i, nand_i, nor_i,
      output a_o, b_o, busy, done, pass, err_vec, fail_vec, vec_idx
   );
endinterface

// File: rtl/all_gate_bist_ctrl.sv
// BIST sequencer for the two-input all_gate block: sweeps {a,b} through all four
// vectors, waits a settle time per vector, and accumulates sticky per-gate and
// per-vector mismatch flags. Reports pass/done at the end of a completed run.
module all_gate_bist_ctrl #(
   parameter int unsigned SETTLE_CYCLES = 2,
   parameter int unsigned PASSES        = 1
) (
   input logic                 clk,
   input logic                 rst,
   all_gate_bist_ctrl_if.slave bus
);

   localparam int unsigned SW = $clog2(SETTLE_CYCLES + 1);
   localparam int unsigned PW = $clog2(PASSES + 1);

   typedef enum logic [2:0] {
      IDLE,
      DRIVE,
      SETTLE,
      CHECK,
      DONE
   } state_t;

   state_t          state_q;
   logic            a_q;
   logic            b_q;
   logic            busy_q;
   logic            done_q;
   logic            pass_q;
   logic [4:0]      err_q;
   logic [3:0]      fail_q;
   logic [1:0]      vec_q;
   logic [SW-1:0]   settle_cnt_q;
   logic [PW-1:0]   pass_cnt_q;

   logic [4:0]      mism;
   logic [4:0]      err_next;
   logic [3:0]      fail_next;
   logic [1:0]      vec_inc;

   // Mismatch of each gate output against the truth table for the applied vector.
   always_comb begin
      mism      = {bus.nor_i  ^ ~(a_q | b_q),
                   bus.nand_i ^ ~(a_q & b_q),
                   bus.xor_i  ^  (a_q ^ b_q),
                   bus.or_i   ^  (a_q | b_q),
                   bus.and_i  ^  (a_q & b_q)};
      err_next  = err_q | mism;
      fail_next = fail_q | (4'(|mism) << vec_q);
      vec_inc   = vec_q + 2'd1;
   end

   // Sequencer FSM; all outputs are registered and a/b only move on DRIVE/IDLE/DONE entry.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         a_q          <= 1'b0;
         b_q          <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         pass_q       <= 1'b0;
         err_q        <= 5'd0;
         fail_q       <= 4'd0;
         vec_q        <= 2'd0;
         settle_cnt_q <= '0;
         pass_cnt_q   <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               a_q    <= 1'b0;
               b_q    <= 1'b0;
               done_q <= 1'b0;
               if (bus.start && !bus.abort) begin
                  err_q      <= 5'd0;
                  fail_q     <= 4'd0;
                  pass_q     <= 1'b0;
                  vec_q      <= 2'd0;
                  pass_cnt_q <= '0;
                  busy_q     <= 1'b1;
                  state_q    <= DRIVE;
               end
            end

            DRIVE: begin
               if (bus.abort) begin
                  a_q     <= 1'b0;
                  b_q     <= 1'b0;
                  busy_q  <= 1'b0;
                  pass_q  <= 1'b0;
                  state_q <= IDLE;
               end else begin
                  settle_cnt_q <= SW'(SETTLE_CYCLES - 1);
                  state_q      <= SETTLE;
               end
            end

            SETTLE: begin
               if (bus.abort) begin
                  a_q     <= 1'b0;
                  b_q     <= 1'b0;
                  busy_q  <= 1'b0;
                  pass_q  <= 1'b0;
                  state_q <= IDLE;
               end else if (settle_cnt_q == '0) begin
                  state_q <= CHECK;
               end else begin
                  settle_cnt_q <= settle_cnt_q - SW'(1);
               end
            end

            CHECK: begin
               if (bus.abort) begin
                  a_q     <= 1'b0;
                  b_q     <= 1'b0;
                  busy_q  <= 1'b0;
                  pass_q  <= 1'b0;
                  state_q <= IDLE;
               end else begin
                  err_q  <= err_next;
                  fail_q <= fail_next;
                  if (vec_q != 2'd3) begin
                     vec_q   <= vec_inc;
                     a_q     <= vec_inc[1];
                     b_q     <= vec_inc[0];
                     state_q <= DRIVE;
                  end else if (pass_cnt_q < PW'(PASSES - 1)) begin
                     pass_cnt_q <= pass_cnt_q + PW'(1);
                     vec_q      <= 2'd0;
                     a_q        <= 1'b0;
                     b_q        <= 1'b0;
                     state_q    <= DRIVE;
                  end else begin
                     a_q     <= 1'b0;
                     b_q     <= 1'b0;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                     pass_q  <= (err_next == 5'd0);
                     state_q <= DONE;
                  end
               end
            end

            DONE: begin
               done_q  <= 1'b0;
               a_q     <= 1'b0;
               b_q     <= 1'b0;
               state_q <= IDLE;
            end

            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign bus.a_o      = a_q;
   assign bus.b_o      = b_q;
   assign bus.busy     = busy_q;
   assign bus.done     = done_q;
   assign bus.pass     = pass_q;
   assign bus.err_vec  = err_q;
   assign bus.fail_vec = fail_q;
   assign bus.vec_idx  = vec_q;

endmodule

// File: tb/tb_all_gate_bist_ctrl.sv
// Bench for all_gate_bist_ctrl: two instances (S=2,P=1 and S=1,P=2) driven by a
// fault-injectable all_gate model; table rows, hand sequences and random runs.
module tb_all_gate_bist_ctrl;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   all_gate_bist_ctrl_if bus0 ();
   all_gate_bist_ctrl_if bus1 ();

   all_gate_bist_ctrl #(.SETTLE_CYCLES(2), .PASSES(1)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
   all_gate_bist_ctrl #(.SETTLE_CYCLES(1), .PASSES(2)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

   // Per-vector fault mask XOR'd onto the ideal gate outputs {NOR,NAND,XOR,OR,AND}.
   logic [3:0][4:0] flip_tab;

   int checks   = 0;
   int failures = 0;

   function automatic logic [4:0] gate_out(input logic a, input logic b, input logic [4:0] f);
      return {~(a | b), ~(a & b), a ^ b, a | b, a & b} ^ f;
   endfunction

   // all_gate model for each instance.
   always_comb {bus0.nor_i, bus0.nand_i, bus0.xor_i, bus0.or_i, bus0.and_i} =
      gate_out(bus0.a_o, bus0.b_o, flip_tab[{bus0.a_o, bus0.b_o}]);
   always_comb {bus1.nor_i, bus1.nand_i, bus1.xor_i, bus1.or_i, bus1.and_i} =
      gate_out(bus1.a_o, bus1.b_o, flip_tab[{bus1.a_o, bus1.b_o}]);

   typedef struct packed {
      logic       busy;
      logic       done;
      logic       pass;
      logic       a;
      logic       b;
      logic [4:0] err;
      logic [3:0] fail;
      logic [1:0] vi;
   } view_t;

   typedef struct {
      string           name;
      logic [3:0][4:0] f;
      logic [4:0]      exp_err;
      logic [3:0]      exp_fail;
      logic            exp_pass;
   } row_t;

   function automatic view_t peek(input int sel);
      view_t v;
      if (sel == 0)
         v = {bus0.busy, bus0.done, bus0.pass, bus0.a_o, bus0.b_o,
              bus0.err_vec, bus0.fail_vec, bus0.vec_idx};
      else
         v = {bus1.busy, bus1.done, bus1.pass, bus1.a_o, bus1.b_o,
              bus1.err_vec, bus1.fail_vec, bus1.vec_idx};
      return v;
   endfunction

   task automatic drive(input int sel, input logic st, input logic ab);
      if (sel == 0) begin
         bus0.start = st;
         bus0.abort = ab;
      end else begin
         bus1.start = st;
         bus1.abort = ab;
      end
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   function automatic int settle_of(input int sel);
      return (sel == 0) ? 2 : 1;
   endfunction

   function automatic int passes_of(input int sel);
      return (sel == 0) ? 1 : 2;
   endfunction

   // Reference: vector i of the run (i counts across passes) is judged at the edge
   // (i+1)*(S+2) after start; an abort sampled at or before that edge drops it.
   task automatic expect_run(input logic [3:0][4:0] f, input int s, input int p, input int ab_k,
                             output logic [4:0] e, output logic [3:0] fl);
      e  = 5'd0;
      fl = 4'd0;
      for (int i = 0; i < 4 * p; i++) begin
         if (ab_k < 0 || (i + 1) * (s + 2) < ab_k) begin
            e         = e | f[i % 4];
            fl[i % 4] = fl[i % 4] | (|f[i % 4]);
         end
      end
   endtask

   // One run: start pulse, optional re-start at edge re_k, optional abort at edge ab_k.
   task automatic run(input int sel, input int re_k, input int ab_k, input string nm,
                      output view_t fin);
      int         s;
      int         p;
      int         lat;
      int         done_at;
      int         bad;
      int         first;
      logic       ok;
      logic       aborted;
      logic [1:0] ev;
      view_t      v;
      s       = settle_of(sel);
      p       = passes_of(sel);
      lat     = 4 * p * (s + 2);
      done_at = -1;
      bad     = 0;
      first   = -1;
      @(negedge clk);
      drive(sel, 1'b1, 1'b0);
      for (int k = 0; k <= lat + 3; k++) begin
         @(posedge clk);
         #1;
         drive(sel, (k + 1 == re_k), (k + 1 == ab_k));
         v = peek(sel);
         if (v.done && done_at < 0) done_at = k;
         aborted = (ab_k >= 0) && (k >= ab_k);
         ev      = 2'((k / (s + 2)) % 4);
         if (aborted)
            ok = !v.busy && !v.done && !v.a && !v.b && !v.pass;
         else if (k < lat)
            ok = v.busy && !v.done && !v.pass && ({v.a, v.b} == ev) && (v.vi == ev) &&
                 (k >= s + 2 || (v.err == 5'd0 && v.fail == 4'd0));
         else
            ok = !v.busy && (v.done == (k == lat)) && !v.a && !v.b;
         if (!ok) begin
            bad++;
            if (first < 0) first = k;
         end
      end
      chk($sformatf("%s_seq(k%0d)", nm, first), 32'(bad), 32'd0);
      chk({nm, "_done_edge"}, 32'(done_at), (ab_k < 0) ? 32'(lat) : 32'hffff_ffff);
      fin = peek(sel);
   endtask

   row_t  rows [7];
   view_t fin;
   int    sel;
   int    ab;
   int    re;
   int    lat;
   int    idle_bad;
   logic [4:0] e_err;
   logic [3:0] e_fail;

   initial begin
      rows[0] = '{"nand_sa0", {5'h00, 5'h08, 5'h08, 5'h08}, 5'b01000, 4'b0111, 1'b0};
      rows[1] = '{"good",     {5'h00, 5'h00, 5'h00, 5'h00}, 5'b00000, 4'b0000, 1'b1};
      rows[2] = '{"xor_11",   {5'h04, 5'h00, 5'h00, 5'h00}, 5'b00100, 4'b1000, 1'b0};
      rows[3] = '{"and_sa1",  {5'h00, 5'h01, 5'h01, 5'h01}, 5'b00001, 4'b0111, 1'b0};
      rows[4] = '{"good2",    {5'h00, 5'h00, 5'h00, 5'h00}, 5'b00000, 4'b0000, 1'b1};
      rows[5] = '{"or_sa0",   {5'h02, 5'h02, 5'h02, 5'h00}, 5'b00010, 4'b1110, 1'b0};
      rows[6] = '{"nor_sa1",  {5'h10, 5'h10, 5'h10, 5'h00}, 5'b10000, 4'b1110, 1'b0};

      flip_tab = '0;
      rst      = 1'b1;
      drive(0, 1'b0, 1'b0);
      drive(1, 1'b0, 1'b0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset0", 32'(peek(0)), 32'd0);
      chk("reset1", 32'(peek(1)), 32'd0);
      rst = 1'b0;

      // Table rows on both instances; failing rows precede good ones to show clearing.
      for (int s = 0; s < 2; s++) begin
         for (int i = 0; i < 7; i++) begin
            flip_tab = rows[i].f;
            run(s, -1, -1, $sformatf("%s_d%0d", rows[i].name, s), fin);
            chk($sformatf("%s_d%0d_err", rows[i].name, s), 32'(fin.err), 32'(rows[i].exp_err));
            chk($sformatf("%s_d%0d_fail", rows[i].name, s), 32'(fin.fail), 32'(rows[i].exp_fail));
            chk($sformatf("%s_d%0d_pass", rows[i].name, s), 32'(fin.pass), 32'(rows[i].exp_pass));
         end
      end

      // Start re-pulsed mid-run is ignored; done timing unchanged.
      flip_tab = '0;
      run(0, 5, -1, "restart", fin);
      chk("restart_pass", 32'(fin.pass), 32'd1);

      // Abort at edge 9 with NAND stuck-at-0: partial sticky flags kept, pass=0.
      flip_tab = rows[0].f;
      run(0, -1, 9, "abort", fin);
      chk("abort_err", 32'(fin.err), 32'(5'b01000));
      chk("abort_fail", 32'(fin.fail), 32'(4'b0011));
      chk("abort_pass", 32'(fin.pass), 32'd0);

      // start and abort together in IDLE: stays idle.
      flip_tab = '0;
      @(negedge clk);
      drive(0, 1'b1, 1'b1);
      idle_bad = 0;
      for (int k = 0; k < 4; k++) begin
         @(posedge clk);
         #1;
         drive(0, 1'b0, 1'b0);
         if (peek(0).busy || peek(0).done) idle_bad++;
      end
      chk("start_abort_idle", 32'(idle_bad), 32'd0);

      // Reset raised in SETTLE clears everything without a clock edge.
      @(negedge clk);
      drive(0, 1'b1, 1'b0);
      @(posedge clk);
      #1;
      drive(0, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      chk("pre_rst_busy", 32'(peek(0).busy), 32'd1);
      rst = 1'b1;
      #1;
      chk("mid_rst_clear", 32'(peek(0)), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      idle_bad = 0;
      for (int k = 0; k < 20; k++) begin
         @(posedge clk);
         #1;
         if (peek(0).done || peek(0).busy) idle_bad++;
      end
      chk("post_rst_no_done", 32'(idle_bad), 32'd0);

      // Random fault masks, random abort / restart points, against the reference.
      for (int n = 0; n < 24; n++) begin
         sel = int'($urandom_range(0, 1));
         lat = 4 * passes_of(sel) * (settle_of(sel) + 2);
         for (int v = 0; v < 4; v++)
            flip_tab[v] = ($urandom_range(0, 2) == 0) ? 5'($urandom) : 5'd0;
         ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, lat - 1)) : -1;
         re = (ab < 0 && $urandom_range(0, 1) == 1) ? int'($urandom_range(1, lat)) : -1;
         expect_run(flip_tab, settle_of(sel), passes_of(sel), ab, e_err, e_fail);
         run(sel, re, ab, $sformatf("rnd%0d", n), fin);
         chk($sformatf("rnd%0d_err", n), 32'(fin.err), 32'(e_err));
         chk($sformatf("rnd%0d_fail", n), 32'(fin.fail), 32'(e_fail));
         chk($sformatf("rnd%0d_pass", n), 32'(fin.pass), 32'((ab < 0) && (e_err == 5'd0)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
